weight_fetch_ctrl: RTL

//   Sequencer for the wide weight ROM. On start it reads a run of num_words_i consecutive
//   ROM words from base_addr_i and streams them to the PE array over valid/ready. It absorbs
//   the ROM's 1-cycle read latency with a 2-entry output buffer and credit-based read issue,
//   so back-pressure never loses a word. Sits between the layer scheduler and rom_weights.

---
 rtl/weight_fetch_ctrl.sv | 177 +++++++++++++++++
 1 files changed

// File: rtl/weight_fetch_ctrl.sv
// weight_fetch_ctrl
//   Sequencer for the wide weight ROM. On start it fetches num_words_i consecutive
//   ROM words beginning at base_addr_i (addresses wrap DEPTH-1 -> 0) and streams them
//   to the PE array over valid/ready. The ROM's 1-cycle read latency is absorbed by a
//   2-entry output buffer; reads are issued only when a buffer slot is guaranteed, so
//   back-pressure never drops a word.
//
// Ports
//   clk_i, rst_n_i   clock (rising edge), asynchronous active-low reset
//   start_i          start pulse, only honoured in IDLE
//   base_addr_i      first ROM address, sampled with start_i
//   num_words_i      run length (0..DEPTH), sampled with start_i
//   busy_o           high from the cycle after an accepted start through done_o
//   done_o           1-cycle pulse when the run is complete
//   rom_rd_en_o      ROM read enable
//   rom_addr_o       ROM read address (registered)
//   rom_rd_i         ROM read data, valid the cycle after rom_rd_en_o
//   w_valid_o        output word valid
//   w_ready_i        consumer ready
//   w_data_o         output word, lane 0 in the LSBs
//   w_last_o         marks the final word of the run
//   stall_cnt_o      (WEIGHT_FETCH_STALL_CNT_EN only) cycles with w_valid_o & !w_ready_i
//
// Configuration macro: WEIGHT_FETCH_STALL_CNT_EN adds the stall_cnt_o counter port.

module weight_fetch_ctrl #(
    parameter int WIDTH   = 8,
    parameter int K       = 4,
    parameter int DEPTH   = 16,
    parameter int DEPTH_W = $clog2(DEPTH),
    parameter int CNT_W   = DEPTH_W + 1
) (
    input  logic                 clk_i,
    input  logic                 rst_n_i,
    input  logic                 start_i,
    input  logic [DEPTH_W-1:0]   base_addr_i,
    input  logic [CNT_W-1:0]     num_words_i,
    output logic                 busy_o,
    output logic                 done_o,
    output logic                 rom_rd_en_o,
    output logic [DEPTH_W-1:0]   rom_addr_o,
    input  logic [K*WIDTH-1:0]   rom_rd_i,
    output logic                 w_valid_o,
    input  logic                 w_ready_i,
    output logic [K*WIDTH-1:0]   w_data_o,
    output logic                 w_last_o
`ifdef WEIGHT_FETCH_STALL_CNT_EN
    ,
    output logic [31:0]          stall_cnt_o
`endif
);

    localparam int DW = K * WIDTH;

    typedef enum logic [1:0] {S_IDLE, S_FETCH, S_DRAIN, S_DONE} state_t;

    state_t               state_q, state_d;
    logic [DEPTH_W-1:0]   addr_q, addr_d;
    logic [CNT_W-1:0]     issue_left_q, issue_left_d;     // reads still to issue
    logic [CNT_W-1:0]     deliver_left_q, deliver_left_d; // words still to hand over
    logic                 inflight_q;                     // read issued last cycle
    logic [1:0]           occ_q;
    logic                 wr_ptr_q, rd_ptr_q;
    logic [1:0][DW-1:0]   buf_q;

    logic                 pop;
    logic                 start_ok;
    logic [2:0]           credit_used;
    logic [DEPTH_W-1:0]   addr_inc;

    assign pop      = w_valid_o & w_ready_i;
    assign start_ok = (state_q == S_IDLE) & start_i;

    // Slots already spoken for: buffered words plus the word arriving from the ROM.
    // A pop this cycle frees one, so the test is occ + inflight - pop < 2, written
    // without subtraction to stay unsigned.
    assign credit_used = {1'b0, occ_q} + {2'b00, inflight_q};
    assign rom_rd_en_o = (state_q == S_FETCH) && (issue_left_q != '0) &&
                         (credit_used < (3'd2 + {2'b00, pop}));

    // DEPTH need not be a power of two, so wrap explicitly.
    assign addr_inc = (addr_q == DEPTH_W'(DEPTH - 1)) ? '0 : addr_q + DEPTH_W'(1);

    assign busy_o     = (state_q != S_IDLE);
    assign done_o     = (state_q == S_DONE);
    assign rom_addr_o = addr_q;
    assign w_valid_o  = (occ_q != 2'd0);
    assign w_data_o   = buf_q[rd_ptr_q];
    assign w_last_o   = w_valid_o && (deliver_left_q == CNT_W'(1));

    always_comb begin
        state_d        = state_q;
        addr_d         = addr_q;
        issue_left_d   = issue_left_q;
        deliver_left_d = deliver_left_q;
        case (state_q)
            S_IDLE: begin
                if (start_i) begin
                    addr_d         = base_addr_i;
                    issue_left_d   = num_words_i;
                    deliver_left_d = num_words_i;
                    state_d        = (num_words_i == '0) ? S_DONE : S_FETCH;
                end
            end
            S_FETCH: begin
                if (rom_rd_en_o) begin
                    addr_d       = addr_inc;
                    issue_left_d = issue_left_q - CNT_W'(1);
                    if (issue_left_q == CNT_W'(1)) state_d = S_DRAIN;
                end
            end
            S_DRAIN: ;
            S_DONE:  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
        // Words can only be popped while a run is active (buffer is empty otherwise).
        if (pop && (state_q == S_FETCH || state_q == S_DRAIN)) begin
            deliver_left_d = deliver_left_q - CNT_W'(1);
            if (deliver_left_q == CNT_W'(1)) state_d = S_DONE;
        end
    end

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            state_q        <= S_IDLE;
            addr_q         <= '0;
            issue_left_q   <= '0;
            deliver_left_q <= '0;
        end else begin
            state_q        <= state_d;
            addr_q         <= addr_d;
            issue_left_q   <= issue_left_d;
            deliver_left_q <= deliver_left_d;
        end
    end

    // Output buffer: ROM data lands the cycle after the issue and is captured at the
    // end of that cycle, so the write strobe is simply the registered issue flag.
    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            inflight_q <= 1'b0;
            occ_q      <= 2'd0;
            wr_ptr_q   <= 1'b0;
            rd_ptr_q   <= 1'b0;
            buf_q      <= '0;
        end else begin
            inflight_q <= rom_rd_en_o;
            occ_q      <= occ_q + {1'b0, inflight_q} - {1'b0, pop};
            if (inflight_q) begin
                buf_q[wr_ptr_q] <= rom_rd_i;
                wr_ptr_q        <= ~wr_ptr_q;
            end
            if (pop) rd_ptr_q <= ~rd_ptr_q;
        end
    end

`ifdef WEIGHT_FETCH_STALL_CNT_EN
    logic [31:0] stall_cnt_q;

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            stall_cnt_q <= '0;
        end else if (start_ok) begin
            stall_cnt_q <= '0;
        end else if (busy_o && w_valid_o && !w_ready_i && (stall_cnt_q != '1)) begin
            stall_cnt_q <= stall_cnt_q + 32'd1;
        end
    end

    assign stall_cnt_o = stall_cnt_q;
`else
    // start_ok only feeds the optional counter.
    logic unused_start_ok;
    assign unused_start_ok = start_ok;
`endif

endmodule
